// File: rtl/vga_sync_rx.sv
// VGA timing receiver: samples active-low hsync/vsync and 3-bit RGB on the
// pixel clock, recovers pixel coordinates and data-enable, checks the raster
// against nominal timing, locks after consecutive clean frames and sums the
// active pixels of each locked frame.
module vga_sync_rx #(
    parameter int HPIXELS     = 800,
    parameter int VLINES      = 521,
    parameter int HPULSE      = 96,
    parameter int VPULSE      = 2,
    parameter int HBP         = 144,
    parameter int HFP         = 784,
    parameter int VBP         = 31,
    parameter int VFP         = 511,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        dclk,
    input  logic        clr,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  red,
    input  logic [2:0]  green,
    input  logic [2:0]  blue,
    input  logic        err_clr,
    output logic        locked,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [2:0]  pix_r,
    output logic [2:0]  pix_g,
    output logic [2:0]  pix_b,
    output logic        frame_start,
    output logic [15:0] frame_sum,
    output logic        err_hlen,
    output logic        err_vlen,
    output logic        err_hpulse,
    output logic        err_vpulse
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    // Typed copies of the raster parameters so every compare is width-matched.
    // Line/frame lengths are 11 bits because a saturated 10-bit counter plus
    // one must still compare unequal to the nominal length.
    localparam logic [10:0] HPIX_C  = 11'(HPIXELS);
    localparam logic [10:0] VLIN_C  = 11'(VLINES);
    localparam logic [9:0]  HPUL_C  = 10'(HPULSE);
    localparam logic [9:0]  VPUL_C  = 10'(VPULSE);
    localparam logic [9:0]  VPUL1_C = 10'(VPULSE + 1);
    localparam logic [9:0]  HBP_C   = 10'(HBP);
    localparam logic [9:0]  HFP_C   = 10'(HFP);
    localparam logic [9:0]  VBP_C   = 10'(VBP);
    localparam logic [9:0]  VFP_C   = 10'(VFP);
    localparam logic [7:0]  LOCK_C  = 8'(LOCK_FRAMES);
    localparam logic [9:0]  SAT_C   = 10'h3FF;

    // Error flag bit order: 0 hlen, 1 vlen, 2 hpulse, 3 vpulse.
    localparam int E_HLEN   = 0;
    localparam int E_VLEN   = 1;
    localparam int E_HPULSE = 2;
    localparam int E_VPULSE = 3;

    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        hs_q, vs_q, vs_d;
    logic [9:0]  pos_q, pos_d;
    logic [9:0]  line_q, line_d;
    logic        locked_q, locked_d;
    logic        de_q, de_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [2:0]  pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic        fs_q;
    logic [15:0] sum_q, sum_d, acc_q, acc_d;
    logic [3:0]  err_q, err_d, err_now;

    logic        h_edge, h_rise, v_edge, v_rise, checking, fail;
    logic [10:0] hlen_len, vlen_len;
    logic [4:0]  rgb_sum;

    // Edge detection, position tracking and the timing checks for the
    // current input sample. vsync is only looked at on line starts, so its
    // previous-value register advances once per h_edge.
    always_comb begin
        h_edge   = hs_q & ~hsync;
        h_rise   = ~hs_q & hsync;
        v_edge   = h_edge & vs_q & ~vsync;
        v_rise   = h_edge & ~vs_q & vsync;
        vs_d     = h_edge ? vsync : vs_q;

        pos_d    = pos_q;
        if (h_edge) begin
            pos_d = '0;
        end else if (pos_q != SAT_C) begin
            pos_d = pos_q + 10'd1;
        end

        line_d   = line_q;
        if (v_edge) begin
            line_d = '0;
        end else if (h_edge && line_q != SAT_C) begin
            line_d = line_q + 10'd1;
        end

        checking = (state_q != SEARCH);
        hlen_len = {1'b0, pos_q} + 11'd1;
        vlen_len = {1'b0, line_q} + 11'd1;

        err_now           = '0;
        err_now[E_HLEN]   = checking & h_edge & (hlen_len != HPIX_C);
        err_now[E_VLEN]   = checking & v_edge & (vlen_len != VLIN_C);
        err_now[E_HPULSE] = checking & ((h_rise & (pos_d != HPUL_C)) |
                                        (~hsync & (pos_d == HPUL_C)));
        err_now[E_VPULSE] = checking & ((v_rise & (line_d != VPUL_C)) |
                                        (h_edge & ~vsync & (line_d == VPUL1_C)));
        fail              = |err_now;
    end

    // Sticky flags: a new error this cycle beats a simultaneous clear.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_err
            assign err_d[gi] = err_now[gi] | (err_q[gi] & ~err_clr);
        end
    endgenerate

    // Lock state machine: next state and good-frame counter.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (v_edge) begin
                    state_d = MEASURE;
                    good_d  = '0;
                end
            end
            MEASURE: begin
                if (fail) begin
                    state_d = SEARCH;
                end else if (v_edge) begin
                    good_d = good_q + 8'd1;
                    if (good_q + 8'd1 == LOCK_C) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (fail) begin
                    state_d = SEARCH;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
        locked_d = (state_d == LOCKED);
    end

    // Active-video decode, pixel outputs and frame checksum accumulation.
    always_comb begin
        de_d    = (state_q == LOCKED) &
                  (pos_d >= HBP_C) & (pos_d < HFP_C) &
                  (line_d >= VBP_C) & (line_d < VFP_C);
        x_d     = de_d ? (pos_d - HBP_C) : '0;
        y_d     = de_d ? (line_d - VBP_C) : '0;
        pr_d    = de_d ? red   : '0;
        pg_d    = de_d ? green : '0;
        pb_d    = de_d ? blue  : '0;
        rgb_sum = {2'b00, red} + {2'b00, green} + {2'b00, blue};

        acc_d   = acc_q;
        sum_d   = sum_q;
        if (state_q == SEARCH) begin
            acc_d = '0;
        end else if (state_q == LOCKED && v_edge) begin
            sum_d = acc_q;
            acc_d = '0;
        end else if (de_d) begin
            acc_d = acc_q + {11'd0, rgb_sum};
        end
    end

    // State register and all output/datapath registers.
    always_ff @(posedge dclk) begin
        if (clr) begin
            state_q  <= SEARCH;
            good_q   <= '0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            pos_q    <= '0;
            line_q   <= '0;
            locked_q <= 1'b0;
            de_q     <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
            fs_q     <= 1'b0;
            sum_q    <= '0;
            acc_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            hs_q     <= hsync;
            vs_q     <= vs_d;
            pos_q    <= pos_d;
            line_q   <= line_d;
            locked_q <= locked_d;
            de_q     <= de_d;
            x_q      <= x_d;
            y_q      <= y_d;
            pr_q     <= pr_d;
            pg_q     <= pg_d;
            pb_q     <= pb_d;
            fs_q     <= v_edge;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
        end
    end

    assign locked      = locked_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign pix_r       = pr_q;
    assign pix_g       = pg_q;
    assign pix_b       = pb_q;
    assign frame_start = fs_q;
    assign frame_sum   = sum_q;
    assign err_hlen    = err_q[E_HLEN];
    assign err_vlen    = err_q[E_VLEN];
    assign err_hpulse  = err_q[E_HPULSE];
    assign err_vpulse  = err_q[E_VPULSE];

endmodule

// File: doc/vga_sync_rx.md
Name: vga_sync_rx

Overview:
- Receiving end of the 640x480 VGA timing interface: samples hsync/vsync (active low) and 3-bit RGB on the pixel clock, and recovers pixel coordinates and a data-enable.
- Checks the timing against the nominal 800x521 raster and locks after consecutive good frames.
- Computes a per-frame pixel checksum.
- Used for on-chip loopback checking of the display path and as a capture front end.

Parameters:
HPIXELS, 800, clocks per line
VLINES, 521, lines per frame
HPULSE, 96, hsync low width in clocks
VPULSE, 2, vsync low width in lines
HBP, 144, first active clock in a line
HFP, 784, first clock after active video in a line
VBP, 31, first active line
VFP, 511, first line after active video
LOCK_FRAMES, 2, consecutive error-free frames required to lock

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr  in  1  reset, synchronous, active-high
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- red  in  3  red sample
- green  in  3  green sample
- blue  in  3  blue sample
- err_clr  in  1  one-cycle pulse; clears all sticky error flags
- locked  out  1  timing locked
- de  out  1  active-video sample valid; only asserted while locked
- x  out  10  active column, 0..639; valid when de
- y  out  10  active row, 0..479; valid when de
- pix_r, pix_g, pix_b  out  3 each  registered RGB; valid when de
- frame_start  out  1  one-cycle pulse on each detected vsync falling edge
- frame_sum  out  16  sum of (r+g+b) over the active pixels of the last complete frame, modulo 2^16
- err_hlen, err_vlen, err_hpulse, err_vpulse  out  1 each  sticky error flags

Behaviour:
- Reset (sampled on dclk edge):
  - hs_q/vs_q (previous-sample regs) = 1, so no false edge is seen.
  - Counters = 0, state = SEARCH.
  - All outputs 0.
- h_edge = hs_q & ~hsync; v_edge = vs_q & ~vsync. v_edge is only evaluated on h_edge cycles.
- Horizontal position:
  - Position of the current input sample is 0 on an h_edge cycle and increments by 1 each clock after it.
  - The counter saturates at 1023.
- Vertical position:
  - The line counter increments on each h_edge.
  - It is set to 0 on an h_edge that coincides with v_edge.
- Latency: every output is registered and describes the input sample from the previous clock.
- de = locked & VBP <= line < VFP & HBP <= pos < HFP, with x = pos - HBP and y = line - VBP. While de = 0, x, y and pix_* hold 0.
- Checks, evaluated only in MEASURE and LOCKED:
  - err_hlen: on h_edge, the cycle count since the previous h_edge != HPIXELS.
  - err_hpulse: on an hsync rising edge, pos != HPULSE; also set if pos reaches HPULSE with hsync still low.
  - err_vpulse: on the h_edge where vsync rises, new line != VPULSE; also set if the line count reaches VPULSE+1 with vsync still low.
  - err_vlen: on v_edge, lines in the frame != VLINES.
- Error flags are sticky. err_clr clears them the next cycle; an error in the same cycle as err_clr wins (flag stays 1).
- FSM:
  - SEARCH: wait for v_edge. On v_edge go to MEASURE with good = 0.
  - MEASURE: any check failure returns to SEARCH. On v_edge with no failure in the frame, good++; when good == LOCK_FRAMES, go to LOCKED.
  - LOCKED: locked = 1. Any check failure sets the flag, drops locked the next cycle and returns to SEARCH.
- frame_start pulses on every v_edge in any state except during reset.
- frame_sum:
  - The accumulator adds r+g+b (5-bit) for each de sample.
  - On v_edge while locked, frame_sum latches the accumulator and the accumulator clears. In SEARCH the accumulator clears.
- Reset mid-frame returns to SEARCH immediately; locked falls on the cycle after clr is sampled.

Test Plan:
- Nominal generator raster with 8 colour bars, clr pulse, then 4 frames:
  - locked rises 2 x 416800 cycles after the first vsync fall.
  - No error flags are set.
- Locked, colour bars:
  - At x=80, y=0, pix = (7,7,0).
  - At x=639, pix = (0,0,0).
  - de is high 640 cycles per active line, for 480 lines.
  - frame_sum = 14336.
- Stretch one line to 801 clocks while locked:
  - err_hlen = 1 and locked = 0 next cycle.
  - Relock after 2 further good frames.
  - err_clr then clears err_hlen.
- hsync width 95 in one line: err_hpulse = 1. vsync width 3 lines: err_vpulse = 1. Frame of 520 lines: err_vlen = 1.
- Assert clr mid-frame while locked:
  - Next cycle locked = 0, de = 0, all flags 0.
  - Lock reacquired 2 frames after the next vsync fall.
- Assert err_clr on the same cycle as a new hlen error: err_hlen remains 1.
